// File: rtl/pipe_mips32.sv
// pipe_mips32: 5-stage in-order MIPS32-subset core (IF/ID/EX/MEM/WB).
// Unified word-addressed memory for code and data. Full EX forwarding.
// Branches resolve in EX. HLT freezes fetch from decode onward.
module pipe_mips32 #(
   parameter int MEM_WORDS = 1024
) (
   input  logic clk,
   input  logic rst,
   output logic halted
);
   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   // Architectural state; names are fixed so benches can reach them.
   logic [31:0] Reg [0:31];
   logic [31:0] Mem [0:MEM_WORDS-1];
   logic [31:0] PC;
   logic        HALTED;
   logic        TAKEN_BRANCH;

   logic [31:0] pc_d;
   logic        halted_d;
   logic        hlt_pend_q, hlt_pend_d;

   // Stage-valid shift register: [0]=IF/ID [1]=ID/EX [2]=EX/MEM [3]=MEM/WB.
   logic [3:0]  vld_q, vld_d;

   logic [31:0] ifid_ir_q, ifid_ir_d, ifid_pc_q, ifid_pc_d;

   logic [5:0]  idex_op_q, idex_op_d;
   logic [4:0]  idex_rs_q, idex_rs_d, idex_rt_q, idex_rt_d, idex_dst_q, idex_dst_d;
   logic        idex_we_q, idex_we_d;
   logic [31:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
   logic [31:0] idex_imm_q, idex_imm_d, idex_npc_q, idex_npc_d;

   logic        exmem_we_q, exmem_we_d, exmem_ld_q, exmem_ld_d;
   logic        exmem_st_q, exmem_st_d, exmem_hlt_q, exmem_hlt_d;
   logic [4:0]  exmem_dst_q, exmem_dst_d;
   logic [31:0] exmem_alu_q, exmem_alu_d, exmem_b_q, exmem_b_d;

   logic        memwb_we_q, memwb_we_d, memwb_hlt_q, memwb_hlt_d;
   logic [4:0]  memwb_dst_q, memwb_dst_d;
   logic [31:0] memwb_res_q, memwb_res_d;

   logic [5:0]  id_op;
   logic [4:0]  id_rs, id_rt, id_rd, id_dst;
   logic        id_we, id_hlt, wb_we;
   logic [31:0] fwd_a, fwd_b, alu, br_target;
   logic        taken;

   // Memory addresses wrap modulo the memory depth.
   function automatic logic [AW-1:0] maddr(input logic [31:0] a);
      return AW'(a % 32'(MEM_WORDS));
   endfunction

   assign wb_we  = vld_q[3] & memwb_we_q;
   assign halted = HALTED;
   assign TAKEN_BRANCH = taken;

   // ID: decode destination and read operands; WB result bypasses the register file.
   always_comb begin
      id_op  = ifid_ir_q[31:26];
      id_rs  = ifid_ir_q[25:21];
      id_rt  = ifid_ir_q[20:16];
      id_rd  = ifid_ir_q[15:11];
      id_we  = 1'b0;
      id_dst = id_rt;
      case (id_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
            id_we  = 1'b1;
            id_dst = id_rd;
         end
         OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: id_we = 1'b1;
         default: id_we = 1'b0;
      endcase
      if (id_dst == 5'd0) id_we = 1'b0;
      id_hlt = vld_q[0] & (id_op == OP_HLT);

      if (id_rs == 5'd0)                          idex_a_d = 32'd0;
      else if (wb_we && memwb_dst_q == id_rs)     idex_a_d = memwb_res_q;
      else                                        idex_a_d = Reg[id_rs];
      if (id_rt == 5'd0)                          idex_b_d = 32'd0;
      else if (wb_we && memwb_dst_q == id_rt)     idex_b_d = memwb_res_q;
      else                                        idex_b_d = Reg[id_rt];

      idex_op_d  = id_op;
      idex_rs_d  = id_rs;
      idex_rt_d  = id_rt;
      idex_dst_d = id_dst;
      idex_we_d  = id_we;
      idex_imm_d = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};
      idex_npc_d = ifid_pc_q + 32'd1;
   end

   // EX: operand forwarding (EX/MEM ALU result first, then MEM/WB), ALU, branch test.
   always_comb begin
      if (vld_q[2] && exmem_we_q && !exmem_ld_q && exmem_dst_q == idex_rs_q) fwd_a = exmem_alu_q;
      else if (wb_we && memwb_dst_q == idex_rs_q)                           fwd_a = memwb_res_q;
      else                                                                   fwd_a = idex_a_q;
      if (vld_q[2] && exmem_we_q && !exmem_ld_q && exmem_dst_q == idex_rt_q) fwd_b = exmem_alu_q;
      else if (wb_we && memwb_dst_q == idex_rt_q)                           fwd_b = memwb_res_q;
      else                                                                   fwd_b = idex_b_q;

      alu = 32'd0;
      case (idex_op_q)
         OP_ADD:                alu = fwd_a + fwd_b;
         OP_SUB:                alu = fwd_a - fwd_b;
         OP_AND:                alu = fwd_a & fwd_b;
         OP_OR:                 alu = fwd_a | fwd_b;
         OP_SLT:                alu = {31'd0, $signed(fwd_a) < $signed(fwd_b)};
         OP_MUL:                alu = fwd_a * fwd_b;
         OP_LW, OP_SW, OP_ADDI: alu = fwd_a + idex_imm_q;
         OP_SUBI:               alu = fwd_a - idex_imm_q;
         OP_SLTI:               alu = {31'd0, $signed(fwd_a) < $signed(idex_imm_q)};
         default:               alu = 32'd0;
      endcase

      br_target = idex_npc_q + idex_imm_q;
      taken = vld_q[1] & ~HALTED &
              (((idex_op_q == OP_BEQZ)  & (fwd_a == 32'd0)) |
               ((idex_op_q == OP_BNEQZ) & (fwd_a != 32'd0)));

      exmem_we_d  = idex_we_q;
      exmem_ld_d  = (idex_op_q == OP_LW);
      exmem_st_d  = (idex_op_q == OP_SW);
      exmem_hlt_d = (idex_op_q == OP_HLT);
      exmem_dst_d = idex_dst_q;
      exmem_alu_d = alu;
      exmem_b_d   = fwd_b;
   end

   // IF/MEM/control: fetch, squash on taken branch, stop fetch once HLT is decoded.
   always_comb begin
      ifid_ir_d   = Mem[maddr(PC)];
      ifid_pc_d   = PC;
      pc_d        = PC;
      vld_d       = {vld_q[2], vld_q[1], vld_q[0] & ~taken, 1'b0};
      if (taken) begin
         pc_d = br_target;
      end else if (!HALTED && !hlt_pend_q && !id_hlt) begin
         pc_d     = PC + 32'd1;
         vld_d[0] = 1'b1;
      end
      hlt_pend_d  = hlt_pend_q | (id_hlt & ~taken);
      halted_d    = HALTED | (vld_q[3] & memwb_hlt_q);

      memwb_we_d  = exmem_we_q;
      memwb_hlt_d = exmem_hlt_q;
      memwb_dst_d = exmem_dst_q;
      memwb_res_d = exmem_ld_q ? Mem[maddr(exmem_alu_q)] : exmem_alu_q;
   end

   // Control state: reset turns every pipeline latch into a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         PC         <= 32'd0;
         HALTED     <= 1'b0;
         hlt_pend_q <= 1'b0;
         vld_q      <= 4'd0;
      end else begin
         PC         <= pc_d;
         HALTED     <= halted_d;
         hlt_pend_q <= hlt_pend_d;
         vld_q      <= vld_d;
      end
   end

   // Pipeline payload; qualified by vld_q so it needs no reset.
   always_ff @(posedge clk) begin
      ifid_ir_q   <= ifid_ir_d;
      ifid_pc_q   <= ifid_pc_d;
      idex_op_q   <= idex_op_d;
      idex_rs_q   <= idex_rs_d;
      idex_rt_q   <= idex_rt_d;
      idex_dst_q  <= idex_dst_d;
      idex_we_q   <= idex_we_d;
      idex_a_q    <= idex_a_d;
      idex_b_q    <= idex_b_d;
      idex_imm_q  <= idex_imm_d;
      idex_npc_q  <= idex_npc_d;
      exmem_we_q  <= exmem_we_d;
      exmem_ld_q  <= exmem_ld_d;
      exmem_st_q  <= exmem_st_d;
      exmem_hlt_q <= exmem_hlt_d;
      exmem_dst_q <= exmem_dst_d;
      exmem_alu_q <= exmem_alu_d;
      exmem_b_q   <= exmem_b_d;
      memwb_we_q  <= memwb_we_d;
      memwb_hlt_q <= memwb_hlt_d;
      memwb_dst_q <= memwb_dst_d;
      memwb_res_q <= memwb_res_d;
   end

   // Register file writeback; suppressed under reset and after halt.
   always_ff @(posedge clk) begin
      if (!rst && !HALTED && wb_we) Reg[memwb_dst_q] <= memwb_res_q;
   end

   // Store port in MEM; suppressed under reset and after halt.
   always_ff @(posedge clk) begin
      if (!rst && !HALTED && vld_q[2] && exmem_st_q) Mem[maddr(exmem_alu_q)] <= exmem_b_q;
   end
endmodule

// File: tb/tb_pipe_mips32.sv
// tb_pipe_mips32: directed programs; expected architectural results are queued
// by the stimulus thread and checked by a monitor when the core presents them.
module tb_pipe_mips32;
   localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_AND = 6'b000010;
   localparam logic [5:0] O_OR = 6'b000011, O_SLT = 6'b000100, O_MUL = 6'b000101;
   localparam logic [5:0] O_LW = 6'b001000, O_SW = 6'b001001, O_ADDI = 6'b001010;
   localparam logic [5:0] O_SUBI = 6'b001011, O_SLTI = 6'b001100, O_BNEQZ = 6'b001101;
   localparam logic [5:0] O_NOP = 6'b010000;
   localparam logic [31:0] HLT = 32'hFC00_0000;
   localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_HALT = 3, K_HCYC = 4, K_TB = 5;

   typedef struct {
      string       name;
      int          kind;
      int          idx;
      logic [31:0] exp;
      int          at;
      bit          wh;
   } chk_t;

   logic clk, rst, halted;
   int   cyc, tcnt, ntot, npass;
   chk_t sb[$];

   pipe_mips32 #(.MEM_WORDS(1024)) dut (.clk(clk), .rst(rst), .halted(halted));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
      return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
      return {op, 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   // Monitor: counts branch pulses and checks queued expectations once ready.
   always @(negedge clk) begin
      chk_t        e;
      logic [31:0] act;
      bit          ok;
      if (rst) tcnt = 0;
      else if (dut.TAKEN_BRANCH) tcnt++;
      while (sb.size() > 0 && cyc >= sb[0].at && (!sb[0].wh || halted)) begin
         e = sb.pop_front();
         case (e.kind)
            K_REG:   act = dut.Reg[e.idx[4:0]];
            K_MEM:   act = dut.Mem[e.idx[9:0]];
            K_PC:    act = dut.PC;
            K_HALT:  act = {31'd0, halted};
            K_HCYC:  act = 32'(cyc);
            default: act = 32'(tcnt);
         endcase
         ok = (e.kind == K_HCYC) ? (act <= e.exp) : (act === e.exp);
         ntot++;
         if (ok) npass++;
         else $display("FAIL %s: actual=0x%08h required=0x%08h", e.name, act, e.exp);
      end
   end

   task automatic push(input string n, input int kind, input int idx, input logic [31:0] exp,
                       input int at = 0, input bit wh = 1'b1);
      chk_t e;
      e.name = n; e.kind = kind; e.idx = idx; e.exp = exp; e.at = at; e.wh = wh;
      sb.push_back(e);
   endtask

   task automatic drain(input int budget);
      chk_t e;
      int   k = 0;
      while (sb.size() > 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         ntot++;
         $display("FAIL %s: timeout, no result, required=0x%08h", e.name, e.exp);
      end
   endtask

   // Hold reset across an edge, then clear program space and preset Reg[k]=k.
   task automatic setup();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 256; i++) dut.Mem[i[9:0]] = 32'd0;
      for (int k = 0; k < 32; k++) dut.Reg[k[4:0]] = 32'(k);
   endtask

   initial begin
      rst = 1'b1; ntot = 0; npass = 0; cyc = 0; tcnt = 0;

      // Reset state
      setup();
      push("rst_pc", K_PC, 0, 32'd0, 0, 1'b0);
      push("rst_halted", K_HALT, 0, 32'd0, 0, 1'b0);
      drain(5);

      // 1: ADDI chain with forwarding from both latches and the register file
      dut.Mem[0] = enc_i(O_ADDI, 1, 0, 10);
      dut.Mem[1] = enc_i(O_ADDI, 2, 0, 20);
      dut.Mem[2] = enc_i(O_ADDI, 3, 0, 25);
      dut.Mem[3] = enc_r(O_ADD, 4, 1, 2);
      dut.Mem[4] = enc_r(O_ADD, 5, 4, 3);
      dut.Mem[5] = HLT;
      push("t1_halt_cycles", K_HCYC, 0, 32'd12);
      push("t1_halted", K_HALT, 0, 32'd1);
      push("t1_r1", K_REG, 1, 32'd10);
      push("t1_r2", K_REG, 2, 32'd20);
      push("t1_r3", K_REG, 3, 32'd25);
      push("t1_r4", K_REG, 4, 32'd30);
      push("t1_r5", K_REG, 5, 32'd55);
      push("t1_r6_untouched", K_REG, 6, 32'd6);
      rst = 1'b0;
      drain(40);
      @(negedge clk);
      ntot++;
      if (dut.Reg[5] === 32'd55) npass++;
      else $display("FAIL t1_r5_direct: actual=0x%08h required=0x%08h", dut.Reg[5], 32'd55);
      ntot++;
      if (halted === 1'b1) npass++;
      else $display("FAIL t1_halted_direct: actual=%b required=1", halted);

      // 2: load, one filler, forward load data, store
      setup();
      dut.Mem[120] = 32'd85;
      dut.Mem[0] = enc_i(O_ADDI, 1, 0, 120);
      dut.Mem[1] = enc_i(O_LW, 2, 1, 0);
      dut.Mem[2] = enc_r(O_OR, 3, 3, 3);
      dut.Mem[3] = enc_i(O_ADDI, 2, 2, 45);
      dut.Mem[4] = enc_i(O_SW, 2, 1, 1);
      dut.Mem[5] = HLT;
      push("t2_mem121", K_MEM, 121, 32'd130);
      push("t2_mem120", K_MEM, 120, 32'd85);
      push("t2_r2", K_REG, 2, 32'd130);
      push("t2_r3", K_REG, 3, 32'd3);
      rst = 1'b0;
      drain(40);
      @(negedge clk);
      ntot++;
      if (dut.Mem[121] === 32'd130) npass++;
      else $display("FAIL t2_mem121_direct: actual=0x%08h required=0x%08h", dut.Mem[121], 32'd130);

      // 3: factorial of Mem[200] into Mem[198]
      setup();
      dut.Mem[200] = 32'd7;
      dut.Mem[0] = enc_i(O_ADDI, 10, 0, 200);
      dut.Mem[1] = enc_i(O_ADDI, 2, 0, 1);
      dut.Mem[2] = enc_i(O_LW, 3, 10, 0);
      dut.Mem[3] = enc_i(O_ADDI, 20, 0, 0);
      dut.Mem[4] = enc_r(O_MUL, 2, 2, 3);
      dut.Mem[5] = enc_i(O_SUBI, 3, 3, 1);
      dut.Mem[6] = enc_i(O_BNEQZ, 0, 3, -3);
      dut.Mem[7] = enc_i(O_ADDI, 21, 21, 1);
      dut.Mem[8] = enc_i(O_SW, 2, 10, -2);
      dut.Mem[9] = HLT;
      push("t3_mem198", K_MEM, 198, 32'd5040);
      push("t3_r2", K_REG, 2, 32'd5040);
      push("t3_r3", K_REG, 3, 32'd0);
      push("t3_shadow_once", K_REG, 21, 32'd22);
      push("t3_taken_count", K_TB, 0, 32'd6);
      rst = 1'b0;
      drain(200);
      @(negedge clk);
      ntot++;
      if (dut.Mem[198] === 32'd5040) npass++;
      else $display("FAIL t3_mem198_direct: actual=0x%08h required=0x%08h", dut.Mem[198], 32'd5040);

      // 4: signed compare, negative arithmetic, unknown opcode
      setup();
      dut.Mem[0]  = enc_i(O_ADDI, 1, 0, 3);
      dut.Mem[1]  = enc_i(O_ADDI, 2, 0, 5);
      dut.Mem[2]  = enc_r(O_SUB, 3, 1, 2);
      dut.Mem[3]  = enc_i(O_ADDI, 4, 0, 1);
      dut.Mem[4]  = enc_r(O_SLT, 5, 3, 4);
      dut.Mem[5]  = enc_r(O_SLT, 6, 4, 3);
      dut.Mem[6]  = enc_i(O_SLTI, 7, 3, -1);
      dut.Mem[7]  = enc_i(O_ADDI, 8, 0, -6);
      dut.Mem[8]  = enc_i(O_ADDI, 9, 0, -7);
      dut.Mem[9]  = enc_r(O_MUL, 10, 8, 9);
      dut.Mem[10] = enc_i(O_ADDI, 11, 0, 6);
      dut.Mem[11] = enc_i(O_ADDI, 12, 0, 7);
      dut.Mem[12] = enc_r(O_MUL, 13, 11, 12);
      dut.Mem[13] = enc_r(O_AND, 14, 3, 2);
      dut.Mem[14] = enc_i(O_SLTI, 15, 4, -1);
      dut.Mem[15] = enc_i(O_SUBI, 17, 1, 10);
      dut.Mem[16] = enc_i(O_NOP, 16, 1, 5);
      dut.Mem[17] = enc_r(O_OR, 18, 8, 2);
      dut.Mem[18] = HLT;
      push("t4_sub", K_REG, 3, 32'hFFFF_FFFE);
      push("t4_slt_neg_lt", K_REG, 5, 32'd1);
      push("t4_slt_pos_gt", K_REG, 6, 32'd0);
      push("t4_slti_neg", K_REG, 7, 32'd1);
      push("t4_mul_negs", K_REG, 10, 32'd42);
      push("t4_mul", K_REG, 13, 32'd42);
      push("t4_and", K_REG, 14, 32'd4);
      push("t4_slti_false", K_REG, 15, 32'd0);
      push("t4_nop_no_write", K_REG, 16, 32'd16);
      push("t4_subi", K_REG, 17, 32'hFFFF_FFF9);
      push("t4_or", K_REG, 18, 32'hFFFF_FFFF);
      rst = 1'b0;
      drain(60);
      @(negedge clk);
      ntot++;
      if (dut.Reg[3] === 32'hFFFF_FFFE) npass++;
      else $display("FAIL t4_sub_direct: actual=0x%08h required=0x%08h", dut.Reg[3], 32'hFFFF_FFFE);

      // 5: nothing after HLT executes; state frozen
      setup();
      dut.Mem[0] = HLT;
      dut.Mem[1] = enc_i(O_ADDI, 9, 0, 1);
      push("t5_halted", K_HALT, 0, 32'd1);
      push("t5_pc", K_PC, 0, 32'd1);
      push("t5_r9", K_REG, 9, 32'd9);
      push("t5_halted_later", K_HALT, 0, 32'd1, 30);
      push("t5_pc_later", K_PC, 0, 32'd1, 30);
      push("t5_r9_later", K_REG, 9, 32'd9, 30);
      rst = 1'b0;
      drain(60);
      @(negedge clk);
      ntot++;
      if (dut.PC === 32'd1) npass++;
      else $display("FAIL t5_pc_direct: actual=0x%08h required=0x%08h", dut.PC, 32'd1);

      // 6a: reset out of halt
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      push("t6_pc_after_rst", K_PC, 0, 32'd0, 0, 1'b0);
      push("t6_halted_after_rst", K_HALT, 0, 32'd0, 0, 1'b0);
      drain(5);

      // 6b: reset while an ADDI sits in WB must drop its write, then rerun cleanly
      setup();
      dut.Mem[0] = enc_i(O_ADDI, 1, 0, 77);
      dut.Mem[1] = enc_i(O_ADDI, 2, 0, 88);
      dut.Mem[2] = HLT;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      push("t6_no_wb_r1", K_REG, 1, 32'd1, 0, 1'b0);
      push("t6_pc_midrun", K_PC, 0, 32'd0, 0, 1'b0);
      drain(5);
      @(negedge clk);
      rst = 1'b0;
      push("t6_rerun_r1", K_REG, 1, 32'd77);
      push("t6_rerun_r2", K_REG, 2, 32'd88);
      drain(40);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
